// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_if
// Description : Bundle of the two requester handshakes and the RAM command
//               bus seen by ram_arbiter. Names are from the arbiter's view:
//               i_* are driven into the arbiter, o_* are driven by it.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // requester 0 (instruction fetch)
  logic              i_req0;
  logic              i_we0;
  logic [ADDR_W-1:0] i_a0;
  logic [DATA_W-1:0] i_d0;
  logic              o_gnt0;
  logic              o_done0;
  logic [DATA_W-1:0] o_q0;
  logic              o_err0;
  // requester 1 (LSU data)
  logic              i_req1;
  logic              i_we1;
  logic [ADDR_W-1:0] i_a1;
  logic [DATA_W-1:0] i_d1;
  logic              o_gnt1;
  logic              o_done1;
  logic [DATA_W-1:0] o_q1;
  logic              o_err1;
  // single-port RAM command bus
  logic [ADDR_W-1:0] o_ram_a;
  logic [DATA_W-1:0] o_ram_d;
  logic              o_ram_re;
  logic              o_ram_we;
  logic [DATA_W-1:0] i_ram_q;
  // status
  logic              o_busy;

  // arbiter side
  modport slave (
    input  i_req0, i_we0, i_a0, i_d0,
    input  i_req1, i_we1, i_a1, i_d1,
    input  i_ram_q,
    output o_gnt0, o_done0, o_q0, o_err0,
    output o_gnt1, o_done1, o_q1, o_err1,
    output o_ram_a, o_ram_d, o_ram_re, o_ram_we,
    output o_busy
  );

  // requesters + RAM side
  modport master (
    output i_req0, i_we0, i_a0, i_d0,
    output i_req1, i_we1, i_a1, i_d1,
    output i_ram_q,
    input  o_gnt0, o_done0, o_q0, o_err0,
    input  o_gnt1, o_done1, o_q1, o_err1,
    input  o_ram_a, o_ram_d, o_ram_re, o_ram_we,
    input  o_busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter
// Description : Two-port arbiter/sequencer in front of a single-port RAM with
//               registered read (1-cycle q latency). One RAM command per
//               transaction, read data captured and returned with done,
//               out-of-range addresses flagged with err and never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RAM_SIZE   = 32768,
  parameter int PRIO_FIXED = 0
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  ram_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_IDLE   = 2'd0;
  localparam logic [1:0]  c_ACCESS = 2'd1;
  localparam logic [1:0]  c_RESP   = 2'd2;
  localparam logic [31:0] c_LIMIT  = RAM_SIZE;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              r_last;     // port that won the most recent grant
  logic              r_port;     // port owning the transaction in flight
  logic              r_we;       // latched write flag of that transaction
  logic              r_oor;      // latched out-of-range flag

  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_done0;
  logic              r_done1;
  logic              r_err0;
  logic              r_err1;
  logic [DATA_W-1:0] r_q0;
  logic [DATA_W-1:0] r_q1;
  logic [ADDR_W-1:0] r_ram_a;
  logic [DATA_W-1:0] r_ram_d;
  logic              r_ram_re;
  logic              r_ram_we;
  logic              r_busy;

  // next values of everything above
  logic              w_last;
  logic              w_port;
  logic              w_we;
  logic              w_oor;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_done0;
  logic              w_done1;
  logic              w_err0;
  logic              w_err1;
  logic [DATA_W-1:0] w_q0;
  logic [DATA_W-1:0] w_q1;
  logic [ADDR_W-1:0] w_ram_a;
  logic [DATA_W-1:0] w_ram_d;
  logic              w_ram_re;
  logic              w_ram_we;

  // --------------------------------------------------------------------------
  // Arbitration and request selection
  // --------------------------------------------------------------------------
  logic              w_any;
  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_d;
  logic              w_sel_oor;

  assign w_any = bus.i_req0 | bus.i_req1;

  // Pick the winner: a lone requester wins; a tie goes to port 0 under fixed
  // priority, otherwise to the port that did not win last time.
  always_comb begin
    w_win = bus.i_req1;
    if (bus.i_req0 && bus.i_req1) begin
      if (PRIO_FIXED != 0) begin
        w_win = 1'b0;
      end else begin
        w_win = ~r_last;
      end
    end
  end

  // Mux the winner's command fields and range-check its address.
  always_comb begin
    w_sel_we  = w_win ? bus.i_we1 : bus.i_we0;
    w_sel_a   = w_win ? bus.i_a1  : bus.i_a0;
    w_sel_d   = w_win ? bus.i_d1  : bus.i_d0;
    w_sel_oor = ({{(32-ADDR_W){1'b0}}, w_sel_a} >= c_LIMIT);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // Hold the sequencer state; reset returns it to IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // IDLE accepts any request; writes and rejected addresses finish after the
  // single ACCESS cycle, reads take one more cycle for the RAM's q.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   w_state_nxt = w_any ? c_ACCESS : c_IDLE;
      c_ACCESS: w_state_nxt = (r_oor || r_we) ? c_IDLE : c_RESP;
      c_RESP:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // --------------------------------------------------------------------------
  // Pulses default low, held data defaults to its current value; each state
  // overrides only what it produces.
  always_comb begin
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_done0  = 1'b0;
    w_done1  = 1'b0;
    w_err0   = 1'b0;
    w_err1   = 1'b0;
    w_q0     = r_q0;
    w_q1     = r_q1;
    w_ram_a  = r_ram_a;
    w_ram_d  = r_ram_d;
    w_ram_re = 1'b0;
    w_ram_we = 1'b0;
    w_last   = r_last;
    w_port   = r_port;
    w_we     = r_we;
    w_oor    = r_oor;
    case (r_state)
      c_IDLE: begin
        if (w_any) begin
          w_last = w_win;
          w_port = w_win;
          w_we   = w_sel_we;
          w_oor  = w_sel_oor;
          if (w_win) begin
            w_gnt1 = 1'b1;
          end else begin
            w_gnt0 = 1'b1;
          end
          // a rejected address never reaches the RAM pins
          if (!w_sel_oor) begin
            w_ram_a  = w_sel_a;
            w_ram_d  = w_sel_d;
            w_ram_we = w_sel_we;
            w_ram_re = ~w_sel_we;
          end
        end
      end
      c_ACCESS: begin
        if (r_oor) begin
          if (r_port) begin
            w_done1 = 1'b1;
            w_err1  = 1'b1;
            w_q1    = '0;
          end else begin
            w_done0 = 1'b1;
            w_err0  = 1'b1;
            w_q0    = '0;
          end
        end else if (r_we) begin
          if (r_port) begin
            w_done1 = 1'b1;
          end else begin
            w_done0 = 1'b1;
          end
        end
      end
      c_RESP: begin
        // the RAM's q is only meaningful one cycle after the read strobe
        if (r_port) begin
          w_done1 = 1'b1;
          w_q1    = bus.i_ram_q;
        end else begin
          w_done0 = 1'b1;
          w_q0    = bus.i_ram_q;
        end
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output and transaction registers
  // --------------------------------------------------------------------------
  // Register every output so the RAM and requesters see glitch-free signals;
  // reset clears them all (last=1 so the first tie goes to port 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_oor    <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_q0     <= '0;
      r_q1     <= '0;
      r_ram_a  <= '0;
      r_ram_d  <= '0;
      r_ram_re <= 1'b0;
      r_ram_we <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_last   <= w_last;
      r_port   <= w_port;
      r_we     <= w_we;
      r_oor    <= w_oor;
      r_gnt0   <= w_gnt0;
      r_gnt1   <= w_gnt1;
      r_done0  <= w_done0;
      r_done1  <= w_done1;
      r_err0   <= w_err0;
      r_err1   <= w_err1;
      r_q0     <= w_q0;
      r_q1     <= w_q1;
      r_ram_a  <= w_ram_a;
      r_ram_d  <= w_ram_d;
      r_ram_re <= w_ram_re;
      r_ram_we <= w_ram_we;
      r_busy   <= (w_state_nxt != c_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Port mapping
  // --------------------------------------------------------------------------
  assign bus.o_gnt0   = r_gnt0;
  assign bus.o_gnt1   = r_gnt1;
  assign bus.o_done0  = r_done0;
  assign bus.o_done1  = r_done1;
  assign bus.o_err0   = r_err0;
  assign bus.o_err1   = r_err1;
  assign bus.o_q0     = r_q0;
  assign bus.o_q1     = r_q1;
  assign bus.o_ram_a  = r_ram_a;
  assign bus.o_ram_d  = r_ram_d;
  assign bus.o_ram_re = r_ram_re;
  assign bus.o_ram_we = r_ram_we;
  assign bus.o_busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter
// Description : Self-checking bench for ram_arbiter. Two instances share the
//               clock/reset: a round-robin one (index 0) and a fixed-priority
//               one (index 1), each with its own behavioural RAM. A
//               transaction-level model predicts every output per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int c_AW   = 16;
  localparam int c_DW   = 8;
  localparam int c_SIZE = 32768;

  logic clk;
  logic rst_n;

  ram_arbiter_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus_rr ();
  ram_arbiter_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus_fx ();

  ram_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .RAM_SIZE(c_SIZE), .PRIO_FIXED(0))
    u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
  ram_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .RAM_SIZE(c_SIZE), .PRIO_FIXED(1))
    u_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bounded wait expired at t=%0t", nm, $time);
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  // ---------------- behavioural RAMs (registered read) ----------------
  logic [7:0] ram_mem [2][c_SIZE];
  logic [7:0] rq0 = 8'h00;
  logic [7:0] rq1 = 8'h00;
  assign bus_rr.i_ram_q = rq0;
  assign bus_fx.i_ram_q = rq1;

  always @(posedge clk) begin
    if (bus_rr.o_ram_re) rq0 <= ram_mem[0][bus_rr.o_ram_a[14:0]];
    if (bus_rr.o_ram_we) ram_mem[0][bus_rr.o_ram_a[14:0]] = bus_rr.o_ram_d;
    if (bus_fx.o_ram_re) rq1 <= ram_mem[1][bus_fx.o_ram_a[14:0]];
    if (bus_fx.o_ram_we) ram_mem[1][bus_fx.o_ram_a[14:0]] = bus_fx.o_ram_d;
  end

  // ---------------- bus access helpers ----------------
  typedef struct packed {
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0] q0, q1;
    logic [15:0] ram_a;
    logic [7:0] ram_d;
    logic       re, we, busy;
  } outs_t;

  function automatic outs_t f_out(input int d);
    outs_t o;
    if (d == 0)
      o = '{bus_rr.o_gnt0, bus_rr.o_gnt1, bus_rr.o_done0, bus_rr.o_done1,
            bus_rr.o_err0, bus_rr.o_err1, bus_rr.o_q0, bus_rr.o_q1,
            bus_rr.o_ram_a, bus_rr.o_ram_d, bus_rr.o_ram_re, bus_rr.o_ram_we, bus_rr.o_busy};
    else
      o = '{bus_fx.o_gnt0, bus_fx.o_gnt1, bus_fx.o_done0, bus_fx.o_done1,
            bus_fx.o_err0, bus_fx.o_err1, bus_fx.o_q0, bus_fx.o_q1,
            bus_fx.o_ram_a, bus_fx.o_ram_d, bus_fx.o_ram_re, bus_fx.o_ram_we, bus_fx.o_busy};
    return o;
  endfunction

  typedef struct packed {
    logic        req, we;
    logic [15:0] a;
    logic [7:0]  d;
  } req_t;

  function automatic req_t f_req(input int d, input int p);
    if (d == 0) return (p == 0) ? req_t'({bus_rr.i_req0, bus_rr.i_we0, bus_rr.i_a0, bus_rr.i_d0})
                                : req_t'({bus_rr.i_req1, bus_rr.i_we1, bus_rr.i_a1, bus_rr.i_d1});
    return (p == 0) ? req_t'({bus_fx.i_req0, bus_fx.i_we0, bus_fx.i_a0, bus_fx.i_d0})
                    : req_t'({bus_fx.i_req1, bus_fx.i_we1, bus_fx.i_a1, bus_fx.i_d1});
  endfunction

  task automatic set_req(input int d, input int p, input logic r, input logic we,
                         input logic [15:0] a, input logic [7:0] dd);
    if (d == 0 && p == 0) begin bus_rr.i_req0 = r; bus_rr.i_we0 = we; bus_rr.i_a0 = a; bus_rr.i_d0 = dd; end
    if (d == 0 && p == 1) begin bus_rr.i_req1 = r; bus_rr.i_we1 = we; bus_rr.i_a1 = a; bus_rr.i_d1 = dd; end
    if (d == 1 && p == 0) begin bus_fx.i_req0 = r; bus_fx.i_we0 = we; bus_fx.i_a0 = a; bus_fx.i_d0 = dd; end
    if (d == 1 && p == 1) begin bus_fx.i_req1 = r; bus_fx.i_we1 = we; bus_fx.i_a1 = a; bus_fx.i_d1 = dd; end
  endtask

  // ---------------- transaction-level model ----------------
  // Per instance: one transaction in flight, described by the edge index at
  // which it was accepted and the edge after which its done shows.
  int         ecnt = 0;
  int         m_last   [2] = '{1, 1};
  int         m_free   [2] = '{0, 0};
  int         m_gnt_e  [2] = '{-100, -100};
  int         m_done_e [2] = '{-100, -100};
  int         m_port   [2] = '{0, 0};
  bit         m_err    [2] = '{0, 0};
  bit         m_str    [2] = '{0, 0};
  bit         m_we     [2] = '{0, 0};
  bit         m_setq   [2] = '{0, 0};
  logic [15:0] m_a     [2] = '{16'h0, 16'h0};
  logic [7:0]  m_d     [2] = '{8'h0, 8'h0};
  logic [7:0]  m_qv    [2] = '{8'h0, 8'h0};
  logic [7:0]  m_qh    [2][2] = '{'{8'h0, 8'h0}, '{8'h0, 8'h0}};
  logic [7:0]  m_mem   [2][c_SIZE];

  always @(posedge clk or negedge rst_n) begin
    ecnt++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_last[d] = 1; m_free[d] = 0; m_gnt_e[d] = -100; m_done_e[d] = -100;
        m_qh[d][0] = 8'h00; m_qh[d][1] = 8'h00;
      end else begin
        req_t r0, r1, rw;
        int   win;
        bit   oor;
        if (ecnt == m_done_e[d] && m_setq[d]) m_qh[d][m_port[d]] = m_qv[d];
        r0 = f_req(d, 0);
        r1 = f_req(d, 1);
        if (ecnt >= m_free[d] && (r0.req || r1.req)) begin
          if (r0.req && r1.req) win = (d == 1) ? 0 : 1 - m_last[d];
          else                  win = r1.req ? 1 : 0;
          rw = (win == 1) ? r1 : r0;
          oor = (int'(rw.a) >= c_SIZE);
          m_last[d] = win; m_port[d] = win; m_gnt_e[d] = ecnt;
          m_str[d] = !oor; m_we[d] = rw.we; m_a[d] = rw.a; m_d[d] = rw.d;
          m_err[d] = oor;
          if (oor) begin
            m_done_e[d] = ecnt + 1; m_free[d] = ecnt + 2; m_qv[d] = 8'h00; m_setq[d] = 1;
          end else if (rw.we) begin
            m_mem[d][rw.a[14:0]] = rw.d;
            m_done_e[d] = ecnt + 1; m_free[d] = ecnt + 2; m_setq[d] = 0;
          end else begin
            m_qv[d] = m_mem[d][rw.a[14:0]];
            m_done_e[d] = ecnt + 2; m_free[d] = ecnt + 3; m_setq[d] = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int         gq   [2][$];
  int         dt1  [$];
  logic [7:0] dq1  [$];

  task automatic cmp(input int d, input string nm, input longint act, input longint exp);
    chk($sformatf("d%0d_%s", d, nm), act, exp);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      outs_t o;
      bit    hg, hd;
      o  = f_out(d);
      hg = (ecnt == m_gnt_e[d]);
      hd = (ecnt == m_done_e[d]);
      cmp(d, "gnt0",  o.gnt0,  hg && m_port[d] == 0);
      cmp(d, "gnt1",  o.gnt1,  hg && m_port[d] == 1);
      cmp(d, "ram_re", o.re,   hg && m_str[d] && !m_we[d]);
      cmp(d, "ram_we", o.we,   hg && m_str[d] && m_we[d]);
      if (hg && m_str[d]) cmp(d, "ram_a", o.ram_a, m_a[d]);
      if (hg && m_str[d] && m_we[d]) cmp(d, "ram_d", o.ram_d, m_d[d]);
      cmp(d, "done0", o.done0, hd && m_port[d] == 0);
      cmp(d, "done1", o.done1, hd && m_port[d] == 1);
      cmp(d, "err0",  o.err0,  hd && m_port[d] == 0 && m_err[d]);
      cmp(d, "err1",  o.err1,  hd && m_port[d] == 1 && m_err[d]);
      cmp(d, "q0",    o.q0,    m_qh[d][0]);
      cmp(d, "q1",    o.q1,    m_qh[d][1]);
      cmp(d, "busy",  o.busy,  ecnt >= m_gnt_e[d] && ecnt < m_done_e[d]);
      if (o.gnt0) gq[d].push_back(0);
      if (o.gnt1) gq[d].push_back(1);
      if (d == 0 && o.done1) begin dt1.push_back(ecnt); dq1.push_back(o.q1); end
    end
  end

  // ---------------- requester driver ----------------
  // Raise a request, wait for its grant (negedges counted from the call),
  // optionally wait for done and return what was seen.
  task automatic txn(input int d, input int p, input logic we, input logic [15:0] a,
                     input logic [7:0] dd, input bit keep, input bit wait_done,
                     output int t_g, output int t_dn, output logic [7:0] q,
                     output logic e, output bit strobe);
    outs_t o;
    t_g = -1; t_dn = -1; q = 8'h00; e = 1'b0; strobe = 1'b0;
    set_req(d, p, 1'b1, we, a, dd);
    for (int i = 1; i <= 40 && t_g < 0; i++) begin
      @(negedge clk);
      o = f_out(d);
      if (o.re || o.we) strobe = 1'b1;
      if ((p == 0) ? o.gnt0 : o.gnt1) t_g = i;
    end
    if (t_g < 0) fail_now($sformatf("d%0d_p%0d_gnt_wait", d, p));
    if (!keep) set_req(d, p, 1'b0, 1'b0, 16'h0000, 8'h00);
    if (wait_done) begin
      for (int i = t_g + 1; i <= t_g + 10 && t_dn < 0; i++) begin
        @(negedge clk);
        o = f_out(d);
        if (o.re || o.we) strobe = 1'b1;
        if ((p == 0) ? o.done0 : o.done1) begin
          t_dn = i;
          q = (p == 0) ? o.q0 : o.q1;
          e = (p == 0) ? o.err0 : o.err1;
        end
      end
      if (t_dn < 0) fail_now($sformatf("d%0d_p%0d_done_wait", d, p));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int tg, td; logic [7:0] q; logic e; bit s;
    outs_t o;
    int e3 [4];
    int e4 [4];
    logic [7:0] e6 [4];

    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < c_SIZE; a++) begin
        ram_mem[d][a] = pat(a);
        m_mem[d][a]   = pat(a);
      end
      set_req(d, 0, 1'b0, 1'b0, 16'h0, 8'h0);
      set_req(d, 1, 1'b0, 1'b0, 16'h0, 8'h0);
    end

    // T1a: reset held with req0 high -> everything stays 0
    rst_n = 1'b0;
    set_req(0, 0, 1'b1, 1'b0, 16'h0010, 8'h00);
    repeat (3) @(negedge clk);
    o = f_out(0);
    chk("t1_rst_gnt0",  o.gnt0, 0);
    chk("t1_rst_busy",  o.busy, 0);
    chk("t1_rst_re",    o.re,   0);
    chk("t1_rst_ram_a", o.ram_a, 0);
    set_req(0, 0, 1'b0, 1'b0, 16'h0, 8'h0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1b: reset during the ACCESS cycle of a read aborts it
    txn(0, 0, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0, tg, td, q, e, s);
    chk("t1_re_in_access", bus_rr.o_ram_re, 1);
    #1 rst_n = 1'b0;
    #1 chk("t1_re_async_drop", bus_rr.o_ram_re, 0);
    chk("t1_busy_async_drop", bus_rr.o_busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t1_no_done0", bus_rr.o_done0, 0);
    end
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T2: single port write then read
    txn(0, 0, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b1, tg, td, q, e, s);
    chk("t2_wr_t_gnt", tg, 1);
    chk("t2_wr_t_done", td, 2);
    chk("t2_wr_strobe", s, 1);
    repeat (2) @(negedge clk);
    txn(0, 0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, tg, td, q, e, s);
    chk("t2_rd_t_gnt", tg, 1);
    chk("t2_rd_t_done", td, 3);
    chk("t2_rd_q0", q, 8'hA5);
    chk("t2_rd_err0", e, 0);
    repeat (2) @(negedge clk);

    // T5: out-of-range write on port 1, then an in-range read
    txn(0, 1, 1'b1, 16'h8000, 8'h5A, 1'b0, 1'b1, tg, td, q, e, s);
    chk("t5_oor_t_done", td, 2);
    chk("t5_oor_no_strobe", s, 0);
    chk("t5_oor_err1", e, 1);
    chk("t5_oor_q1", q, 8'h00);
    repeat (2) @(negedge clk);
    txn(0, 1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, tg, td, q, e, s);
    chk("t5_rd_t_done", td, 3);
    chk("t5_rd_q1", q, 8'h03);
    chk("t5_rd_err1", e, 0);
    repeat (2) @(negedge clk);

    // T3: round-robin with both ports held (last grant was port 1)
    gq[0].delete();
    fork
      begin
        int g0, d0; logic [7:0] q0; logic e0; bit s0;
        txn(0, 0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, g0, d0, q0, e0, s0);
        txn(0, 0, 1'b0, 16'h0011, 8'h00, 1'b0, 1'b0, g0, d0, q0, e0, s0);
      end
      begin
        int g1, d1; logic [7:0] q1; logic e1; bit s1;
        txn(0, 1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, g1, d1, q1, e1, s1);
        txn(0, 1, 1'b0, 16'h0021, 8'h00, 1'b0, 1'b0, g1, d1, q1, e1, s1);
      end
    join
    repeat (4) @(negedge clk);
    e3 = '{0, 1, 0, 1};
    chk("t3_grant_count", gq[0].size(), 4);
    for (int i = 0; i < 4 && i < gq[0].size(); i++)
      chk($sformatf("t3_grant_%0d", i), gq[0][i], e3[i]);

    // T6: port 1 keeps req high for four back-to-back reads
    dt1.delete(); dq1.delete();
    for (int a = 1; a <= 4; a++)
      txn(0, 1, 1'b0, 16'(a), 8'h00, (a < 4), 1'b0, tg, td, q, e, s);
    repeat (4) @(negedge clk);
    e6 = '{8'h0A, 8'h11, 8'h18, 8'h1F};
    chk("t6_done_count", dt1.size(), 4);
    for (int i = 0; i < 4 && i < dq1.size(); i++)
      chk($sformatf("t6_q1_%0d", i), dq1[i], e6[i]);
    for (int i = 0; i < 3 && i + 1 < dt1.size(); i++)
      chk($sformatf("t6_spacing_%0d", i), dt1[i+1] - dt1[i], 3);

    // T4: fixed priority instance, both ports held
    gq[1].delete();
    fork
      begin
        int g0, d0; logic [7:0] q0; logic e0; bit s0;
        txn(1, 0, 1'b0, 16'h0030, 8'h00, 1'b1, 1'b0, g0, d0, q0, e0, s0);
        txn(1, 0, 1'b0, 16'h0031, 8'h00, 1'b0, 1'b0, g0, d0, q0, e0, s0);
      end
      begin
        int g1, d1; logic [7:0] q1; logic e1; bit s1;
        txn(1, 1, 1'b0, 16'h0040, 8'h00, 1'b1, 1'b0, g1, d1, q1, e1, s1);
        txn(1, 1, 1'b0, 16'h0041, 8'h00, 1'b0, 1'b0, g1, d1, q1, e1, s1);
      end
    join
    repeat (4) @(negedge clk);
    e4 = '{0, 0, 1, 1};
    chk("t4_grant_count", gq[1].size(), 4);
    for (int i = 0; i < 4 && i < gq[1].size(); i++)
      chk($sformatf("t4_grant_%0d", i), gq[1][i], e4[i]);
    chk("t4_last_q1", bus_fx.o_q1, pat(16'h0041));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    fail_now("global_timeout");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
